// File: rtl/serial_word_feeder_if.sv
// rtl/serial_word_feeder_if.sv - word handshake and serial output bundle for serial_word_feeder
interface serial_word_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             j;
    logic             j_valid;
    logic             frame_done;
    logic [7:0]       words_sent;

    modport master (
        output din, din_valid,
        input  din_ready, j, j_valid, frame_done, words_sent
    );

    modport slave (
        input  din, din_valid,
        output din_ready, j, j_valid, frame_done, words_sent
    );
endinterface

// File: rtl/serial_word_feeder.sv
// rtl/serial_word_feeder.sv - parallel word to serial bit stream feeder; PARITY_EN adds an even-parity trailer bit
module serial_word_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    serial_word_feeder_if.slave bus
);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] shift_reg, shift_n;
    logic [CW-1:0]    bit_cnt, cnt_n;
    logic             j_q, j_n;
    logic             jv_q, jv_n;
    logic             fd_q, fd_n;
    logic [7:0]       ws_q, ws_n;
    logic             end_frame;
    logic             ready;
    logic             accept;
`ifdef PARITY_EN
    logic             par_q, par_n;

    assign end_frame = (state == PARITY);
`else
    assign end_frame = (state == SHIFT) && (bit_cnt == LAST);
`endif

    // Ready comes only from registered state, so din never reaches j combinationally
    assign ready  = (state == IDLE) || end_frame;
    assign accept = bus.din_valid && ready;

    assign bus.din_ready  = ready;
    assign bus.j          = j_q;
    assign bus.j_valid    = jv_q;
    assign bus.frame_done = fd_q;
    assign bus.words_sent = ws_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            j_q       <= IDLE_BIT;
            jv_q      <= 1'b0;
            fd_q      <= 1'b0;
            ws_q      <= 8'd0;
`ifdef PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            bit_cnt   <= cnt_n;
            j_q       <= j_n;
            jv_q      <= jv_n;
            fd_q      <= fd_n;
            ws_q      <= ws_n;
`ifdef PARITY_EN
            par_q     <= par_n;
`endif
        end
    end

    // shift_reg holds the bits not yet placed on j; j_q is the bit on the line now
    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        cnt_n   = bit_cnt;
        j_n     = j_q;
        jv_n    = jv_q;
        fd_n    = 1'b0;
        ws_n    = ws_q;
`ifdef PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            SHIFT: begin
                if (bit_cnt != LAST) begin
                    cnt_n   = bit_cnt + CW'(1);
                    j_n     = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
                    shift_n = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
`ifndef PARITY_EN
                    fd_n    = (cnt_n == LAST);
`endif
                end else begin
`ifdef PARITY_EN
                    state_n = PARITY;
                    j_n     = par_q;
                    fd_n    = 1'b1;
`else
                    state_n = IDLE;
                    j_n     = IDLE_BIT;
                    jv_n    = 1'b0;
                    cnt_n   = '0;
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                state_n = IDLE;
                j_n     = IDLE_BIT;
                jv_n    = 1'b0;
                cnt_n   = '0;
            end
`endif
            default: ;
        endcase

        // A transfer on an end-of-frame edge chains straight into the next word
        if (accept) begin
            state_n = SHIFT;
            cnt_n   = '0;
            j_n     = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
            shift_n = MSB_FIRST ? (bus.din << 1) : (bus.din >> 1);
            jv_n    = 1'b1;
            fd_n    = 1'b0;
            ws_n    = ws_q + 8'd1;
`ifdef PARITY_EN
            par_n   = ^bus.din;
`endif
        end
    end
endmodule

// File: tb/tb_serial_word_feeder.sv
// tb/tb_serial_word_feeder.sv - randomized scoreboard bench for serial_word_feeder
module tb_serial_word_feeder;
    localparam int W         = 8;
    localparam bit MSB       = 1'b1;
    localparam bit IDLE_LVL  = 1'b0;

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    logic       clock;
    logic       reset;
    exp_t       q[$];
    logic [7:0] exp_ws;
    int         total;
    int         bad;

    serial_word_feeder_if #(.WIDTH(W)) bus ();

    serial_word_feeder #(
        .WIDTH     (W),
        .MSB_FIRST (MSB),
        .IDLE_BIT  (IDLE_LVL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame is the word's bits in send order, then the XOR of them when parity is on
    task automatic push_word(input logic [W-1:0] d);
        exp_t e;
        logic par;
        par = 1'b0;
        for (int i = 0; i < W; i++) begin
            e.b    = d[MSB ? (W - 1 - i) : i];
            par    = par ^ e.b;
`ifdef PARITY_EN
            e.last = 1'b0;
`else
            e.last = (i == W - 1);
`endif
            q.push_back(e);
        end
`ifdef PARITY_EN
        e.b    = par;
        e.last = 1'b1;
        q.push_back(e);
`endif
        exp_ws = exp_ws + 8'd1;
    endtask

    // Inputs change just after the falling edge; the model sees a transfer when it is free
    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, output logic acc);
        @(negedge clock);
        #1;
        reset         = r;
        bus.din_valid = v;
        bus.din       = d;
        acc           = 1'b0;
        if (r) begin
            q.delete();
            exp_ws = 8'd0;
        end else if (v && q.size() == 0) begin
            push_word(d);
            acc = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) drive(1'b0, W'($urandom), 1'b0, a);
    endtask

    task automatic send_word(input logic [W-1:0] d);
        logic a;
        int   n;
        a = 1'b0;
        n = 0;
        while (!a && n < 40) begin
            drive(1'b1, d, 1'b0, a);
            n++;
        end
        total++;
        if (!a) begin
            bad++;
            $display("FAIL send_word_timeout actual=%0d expected=accept word=%0h", n, d);
        end
    endtask

    // Monitor: each cycle compares the line against the next expected item or idle
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() == 0) begin
                chk("j_valid_idle", 32'(bus.j_valid), 32'd0);
                chk("j_idle", 32'(bus.j), 32'(IDLE_LVL));
                chk("frame_done_idle", 32'(bus.frame_done), 32'd0);
                chk("din_ready_idle", 32'(bus.din_ready), 32'd1);
            end else begin
                e = q.pop_front();
                chk("j_valid", 32'(bus.j_valid), 32'd1);
                chk("j_bit", 32'(bus.j), 32'(e.b));
                chk("frame_done", 32'(bus.frame_done), 32'(e.last));
                chk("din_ready", 32'(bus.din_ready), 32'(e.last));
            end
            chk("words_sent", 32'(bus.words_sent), 32'(exp_ws));
        end
    end

    initial begin
        logic a;
        total         = 0;
        bad           = 0;
        exp_ws        = 8'd0;
        reset         = 1'b1;
        bus.din_valid = 1'b0;
        bus.din       = '0;

        drive(1'b0, '0, 1'b1, a);
        drive(1'b0, '0, 1'b1, a);
        idle(3);

        send_word(8'b1001_0010);
        idle(10);

        send_word(8'hA5);
        send_word(8'h3C);
        idle(12);

        send_word(8'h5A);
        for (int i = 0; i < 4; i++) drive(1'b1, W'($urandom), 1'b0, a);
        drive(1'b0, '0, 1'b1, a);
        send_word(8'hC3);
        idle(12);

`ifdef PARITY_EN
        send_word(8'b1011_0000);
        send_word(8'h01);
        idle(12);
`endif

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) != 0, W'($urandom), $urandom_range(0, 299) == 0, a);
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
